// File: rtl/mem_io_responder_pkg.sv
// Shared definitions for the processor memory-port responder.
// Holds the address region codes decoded from ADDR[15:12] and the
// register offsets of the timer block (ADDR[1:0] inside the timer region).
package mem_io_responder_pkg;

  // Address regions, selected by ADDR[15:12]
  localparam logic [3:0] REG_RAM = 4'h0;
  localparam logic [3:0] REG_LED = 4'h1;
  localparam logic [3:0] REG_SW  = 4'h3;
  localparam logic [3:0] REG_TMR = 4'h5;

  // Region code held in the read-side pipeline after reset; it decodes
  // as "no device", so DIN reads as zero until a real access arrives
  localparam logic [3:0] REG_NONE = 4'hF;

  // Timer register offsets, selected by ADDR[1:0]
  localparam logic [1:0] TMR_RELOAD = 2'd0;
  localparam logic [1:0] TMR_CTRL   = 2'd1;
  localparam logic [1:0] TMR_COUNT  = 2'd2;
  localparam logic [1:0] TMR_STATUS = 2'd3;

endpackage

// File: rtl/mem_io_responder_if.sv
// Processor memory-port bundle.
//   ADDR : word address driven by the processor
//   DOUT : write data driven by the processor
//   W    : write strobe driven by the processor
//   DIN  : registered read data returned by the responder
// master = processor side, slave = responder side.
interface mem_io_responder_if;

  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic [15:0] DIN;

  modport master (output ADDR, output DOUT, output W, input DIN);
  modport slave  (input ADDR, input DOUT, input W, output DIN);

endinterface

// File: rtl/mem_io_responder_ram.sv
// Single-port synchronous word RAM with a registered read port.
// Ports:
//   Clock : system clock
//   we    : write enable, commits wdata to addr at the rising edge
//   addr  : word address
//   wdata : write data
//   rdata : read data for the address of the previous cycle
// Contents are never reset. A read and a write to the same word in one
// cycle return the old contents (read-before-write).
module ram_sync #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          Clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge Clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-port responder: decodes the processor's ADDR/DOUT/W and services
// them from a word RAM, an LED register, a synchronized switch port and a
// down-counting timer. Read data appears on DIN one cycle after ADDR.
// Ports:
//   Clock, Resetn : clock and synchronous active-low reset
//   bus           : processor bundle (ADDR, DOUT, W in; DIN out)
//   SW            : asynchronous board switches
//   LEDR          : LED register
//   TmrFlag       : sticky timer-expired status
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_AW = 8,
  parameter int SW_W   = 10,
  parameter int LED_W  = 10,
  parameter int TMR_W  = 16
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  mem_io_responder_if.slave    bus,
  input  logic [SW_W-1:0]      SW,
  output logic [LED_W-1:0]     LEDR,
  output logic                 TmrFlag
);

  logic [3:0]       region;
  logic [1:0]       tmr_off;
  logic             wr_ram;
  logic             wr_led;
  logic             wr_tmr;
  logic [15:0]      ram_rdata;
  logic [SW_W-1:0]  sw_meta;
  logic [SW_W-1:0]  sw_sync;
  logic [LED_W-1:0] led_q;
  logic [TMR_W-1:0] reload_q;
  logic [TMR_W-1:0] count_q;
  logic             en_q;
  logic             expired_q;
  logic             expire;
  logic [15:0]      periph_rd;
  logic [15:0]      periph_q;
  logic [3:0]       region_q;
  logic             unused_addr;

  assign region  = bus.ADDR[15:12];
  assign tmr_off = bus.ADDR[1:0];
  assign wr_ram  = bus.W && (region == REG_RAM);
  assign wr_led  = bus.W && (region == REG_LED);
  assign wr_tmr  = bus.W && (region == REG_TMR);

  // Address bits between the RAM index and the region code are ignored,
  // which makes the RAM alias across the whole region
  assign unused_addr = ^bus.ADDR[11:RAM_AW];

  // RAM writes are not gated by reset, so a write during reset still lands
  ram_sync #(.AW(RAM_AW), .DW(16)) u_ram (
    .Clock (Clock),
    .we    (wr_ram),
    .addr  (bus.ADDR[RAM_AW-1:0]),
    .wdata (bus.DOUT),
    .rdata (ram_rdata)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      led_q <= '0;
    end else if (wr_led) begin
      led_q <= bus.DOUT[LED_W-1:0];
    end
  end

  // An enabled timer sitting at zero expires this cycle
  assign expire = en_q && (count_q == '0);

  // Timer registers; a RELOAD write overrides both the decrement and the
  // automatic reload of COUNT
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      reload_q <= '0;
      en_q     <= 1'b0;
      count_q  <= '0;
    end else begin
      if (wr_tmr && tmr_off == TMR_CTRL) begin
        en_q <= bus.DOUT[0];
      end
      if (wr_tmr && tmr_off == TMR_RELOAD) begin
        reload_q <= bus.DOUT[TMR_W-1:0];
        count_q  <= bus.DOUT[TMR_W-1:0];
      end else if (expire) begin
        count_q <= reload_q;
      end else if (en_q) begin
        count_q <= count_q - TMR_W'(1);
      end
    end
  end

  // Sticky expired flag; a new expiry beats a simultaneous write-1-clear
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      expired_q <= 1'b0;
    end else if (expire) begin
      expired_q <= 1'b1;
    end else if (wr_tmr && tmr_off == TMR_STATUS && bus.DOUT[0]) begin
      expired_q <= 1'b0;
    end
  end

  // Peripheral read value for the current address, taken from register
  // state before any write of this cycle lands
  always_comb begin
    periph_rd = '0;
    case (region)
      REG_LED: periph_rd = 16'(led_q);
      REG_SW:  periph_rd = 16'(sw_sync);
      REG_TMR: begin
        case (tmr_off)
          TMR_RELOAD: periph_rd = 16'(reload_q);
          TMR_CTRL:   periph_rd = 16'(en_q);
          TMR_COUNT:  periph_rd = 16'(count_q);
          TMR_STATUS: periph_rd = 16'(expired_q);
          default:    periph_rd = '0;
        endcase
      end
      default: periph_rd = '0;
    endcase
  end

  // Read pipeline stage that lines peripheral data up with the RAM output
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      periph_q <= '0;
      region_q <= REG_NONE;
    end else begin
      periph_q <= periph_rd;
      region_q <= region;
    end
  end

  assign bus.DIN = (region_q == REG_RAM) ? ram_rdata : periph_q;
  assign LEDR    = led_q;
  assign TmrFlag = expired_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder. Stimulus pushes expected
// responses into a queue; a monitor pops and compares after each edge.
module tb_mem_io_responder;
  import mem_io_responder_pkg::*;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] din;
    bit          din_care;
    logic [9:0]  led;
    bit          flag;
  } exp_t;

  logic       Clock;
  logic       Resetn;
  logic [9:0] SW;
  logic [9:0] LEDR;
  logic       TmrFlag;

  mem_io_responder_if bus();

  mem_io_responder #(
    .RAM_AW(8), .SW_W(10), .LED_W(10), .TMR_W(16)
  ) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .bus     (bus),
    .SW      (SW),
    .LEDR    (LEDR),
    .TmrFlag (TmrFlag)
  );

  int checks = 0;
  int fails  = 0;
  exp_t exp_q[$];

  // Reference model state
  logic [15:0] ram_m [int];
  logic [9:0]  led_m;
  int          reload_m;
  int          count_m;
  bit          en_m;
  bit          expired_m;
  logic [9:0]  sw_hist[$];

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input exp_t e);
    if (e.din_care) begin
      checks++;
      if (bus.DIN !== e.din) begin
        fails++;
        $display("[TB] FAIL din@%h: got %h expected %h", e.addr, bus.DIN, e.din);
      end
    end
    checks++;
    if (LEDR !== e.led) begin
      fails++;
      $display("[TB] FAIL ledr@%h: got %h expected %h", e.addr, LEDR, e.led);
    end
    checks++;
    if (TmrFlag !== e.flag) begin
      fails++;
      $display("[TB] FAIL tmrflag@%h: got %b expected %b", e.addr, TmrFlag, e.flag);
    end
  endtask

  // Monitor: expectations pushed before an edge are checked just after it
  initial begin
    forever begin
      @(posedge Clock);
      #1;
      if (exp_q.size() > 0) begin
        checkOutput(exp_q.pop_front());
      end
    end
  end

  // Drive one bus cycle and advance the reference model across its edge
  task automatic applyStimulus(input bit rst_n, input logic [15:0] addr,
                               input logic [15:0] dout, input bit w,
                               input logic [9:0] sw);
    exp_t e;
    bit   expire;
    @(negedge Clock);
    Resetn   = rst_n;
    bus.ADDR = addr;
    bus.DOUT = dout;
    bus.W    = w;
    SW       = sw;

    e.addr     = addr;
    e.din      = 16'h0000;
    e.din_care = 1'b1;
    if (rst_n) begin
      case (addr[15:12])
        REG_RAM: begin
          if (ram_m.exists(int'(addr[7:0]))) e.din = ram_m[int'(addr[7:0])];
          else e.din_care = 1'b0;
        end
        REG_LED: e.din = {6'd0, led_m};
        REG_SW:  e.din = {6'd0, sw_hist[0]};
        REG_TMR: begin
          case (addr[1:0])
            2'd0:    e.din = 16'(reload_m);
            2'd1:    e.din = {15'd0, en_m};
            2'd2:    e.din = 16'(count_m);
            default: e.din = {15'd0, expired_m};
          endcase
        end
        default: e.din = 16'h0000;
      endcase
    end

    if (w && addr[15:12] == REG_RAM) ram_m[int'(addr[7:0])] = dout;

    if (!rst_n) begin
      led_m = '0; reload_m = 0; count_m = 0; en_m = 0; expired_m = 0;
      sw_hist = '{10'd0, 10'd0};
    end else begin
      void'(sw_hist.pop_front());
      sw_hist.push_back(sw);
      if (w && addr[15:12] == REG_LED) led_m = dout[9:0];
      expire = en_m && (count_m == 0);
      if (w && addr[15:12] == REG_TMR && addr[1:0] == 2'd0) begin
        reload_m = int'(dout);
        count_m  = int'(dout);
      end else if (expire) begin
        count_m = reload_m;
      end else if (en_m) begin
        count_m = count_m - 1;
      end
      if (w && addr[15:12] == REG_TMR && addr[1:0] == 2'd1) en_m = dout[0];
      if (expire) expired_m = 1'b1;
      else if (w && addr[15:12] == REG_TMR && addr[1:0] == 2'd3 && dout[0]) expired_m = 1'b0;
    end

    e.led  = led_m;
    e.flag = expired_m;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [15:0] addr;
    logic [15:0] dout;
    logic [9:0]  sw;
    logic [3:0]  other [4];
    bit          w;
    bit          rst_n;
    other = '{4'h2, 4'h4, 4'h7, 4'hF};
    Resetn = 1'b0; bus.W = 1'b0; bus.ADDR = '0; bus.DOUT = '0; SW = '0;
    sw_hist = '{10'd0, 10'd0};

    // Reset, including a RAM write that must still commit
    applyStimulus(0, 16'h1000, 16'h0000, 0, 10'h000);
    applyStimulus(0, 16'h0009, 16'hCAFE, 1, 10'h000);
    applyStimulus(0, 16'h1000, 16'h0000, 0, 10'h000);
    applyStimulus(1, 16'h1000, 16'h0000, 0, 10'h000);

    // RAM write, read-back and aliasing
    applyStimulus(1, 16'h0005, 16'hBEEF, 1, 10'h000);
    applyStimulus(1, 16'h0005, 16'h0000, 0, 10'h000);
    applyStimulus(1, 16'h0105, 16'h0000, 0, 10'h000);
    applyStimulus(1, 16'h0009, 16'h0000, 0, 10'h000);

    // Read-during-write returns old data
    applyStimulus(1, 16'h0007, 16'h1111, 1, 10'h000);
    applyStimulus(1, 16'h0007, 16'h2222, 1, 10'h000);
    applyStimulus(1, 16'h0007, 16'h0000, 0, 10'h000);

    // LED, read-only SW, unmapped region
    applyStimulus(1, 16'h1000, 16'h03FF, 1, 10'h000);
    applyStimulus(1, 16'h1000, 16'h0000, 0, 10'h000);
    applyStimulus(1, 16'h3000, 16'h1234, 1, 10'h000);
    applyStimulus(1, 16'h7000, 16'hFFFF, 1, 10'h000);
    applyStimulus(1, 16'h7000, 16'h0000, 0, 10'h000);

    // Switch synchronizer latency
    for (int i = 0; i < 5; i++) applyStimulus(1, 16'h3000, 16'h0000, 0, 10'h2A5);

    // Timer countdown and expiry
    applyStimulus(1, 16'h5000, 16'h0003, 1, 10'h2A5);
    applyStimulus(1, 16'h5001, 16'h0001, 1, 10'h2A5);
    for (int i = 0; i < 5; i++) applyStimulus(1, 16'h5002, 16'h0000, 0, 10'h2A5);
    applyStimulus(1, 16'h5002, 16'hFFFF, 1, 10'h2A5);
    applyStimulus(1, 16'h5003, 16'h0000, 0, 10'h2A5);
    applyStimulus(1, 16'h5003, 16'h0001, 1, 10'h2A5);
    applyStimulus(1, 16'h5003, 16'h0000, 0, 10'h2A5);

    // RELOAD=0 expires every cycle, so a clear cannot win
    applyStimulus(1, 16'h5000, 16'h0000, 1, 10'h2A5);
    applyStimulus(1, 16'h5003, 16'h0000, 0, 10'h2A5);
    applyStimulus(1, 16'h5003, 16'h0001, 1, 10'h2A5);
    applyStimulus(1, 16'h5003, 16'h0000, 0, 10'h2A5);
    applyStimulus(1, 16'h5001, 16'h0000, 1, 10'h2A5);
    applyStimulus(1, 16'h5003, 16'h0001, 1, 10'h2A5);
    applyStimulus(1, 16'h5003, 16'h0000, 0, 10'h2A5);

    // Randomized traffic over all regions, with occasional resets
    sw = 10'h2A5;
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: addr = {4'h0, 4'($urandom), 4'h0, 4'($urandom_range(0, 15))};
        3:       addr = {REG_LED, 12'($urandom)};
        4:       addr = {REG_SW, 12'($urandom)};
        5, 6, 7: addr = {REG_TMR, 12'($urandom)};
        default: addr = {other[$urandom_range(0, 3)], 12'($urandom)};
      endcase
      if (addr[15:12] == REG_TMR && addr[1:0] == TMR_RELOAD)
        dout = 16'($urandom_range(0, 6));
      else
        dout = 16'($urandom);
      w = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 7) == 0) sw = 10'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      applyStimulus(rst_n, addr, dout, w, sw);
    end

    repeat (2) @(posedge Clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Bus responder for the processor's memory port. It decodes the registered `ADDR`/`DOUT`/`W` outputs of the processor and services them from a synchronous word RAM, an LED register, a synchronized switch port and a down-counting timer. It returns read data on `DIN` with exactly one cycle of latency, which matches the processor's fetch and load wait cycles. It sits at top level between `proc` and the board I/O.

## Interface
- `RAM_AW`, 8: RAM address width in words; depth is 2^RAM_AW.
- `SW_W`, 10: switch port width.
- `LED_W`, 10: LED register width.
- `TMR_W`, 16: timer width; must be ≤16.

Ports:
- `Clock`  in  1  system clock.
- `Resetn`  in  1  synchronous, active-low reset.
- `ADDR`  in  16  word address from the processor.
- `DOUT`  in  16  write data from the processor.
- `W`  in  1  write strobe; 1 = write `DOUT` to `ADDR` this cycle.
- `DIN`  out  16  registered read data to the processor.
- `SW`  in  SW_W  asynchronous board switches.
- `LEDR`  out  LED_W  LED register.
- `TmrFlag`  out  1  sticky timer-expired status, for polling or a future interrupt.

## Operation
- Decode uses `ADDR[15:12]`:
  - 0x0: RAM, word index `ADDR[RAM_AW-1:0]`; upper bits are ignored, so the RAM aliases.
  - 0x1: LEDR, read/write; reads return the value zero-extended.
  - 0x3: SW, read-only; reads return the synchronized value zero-extended; writes are ignored.
  - 0x5: timer, with the offset in `ADDR[1:0]`:
    - 0 RELOAD, read/write.
    - 1 CTRL, read/write, bit0 = EN.
    - 2 COUNT, read-only.
    - 3 STATUS, bit0 = expired; writing 1 to bit0 clears it.
  - Any other region: reads return 0x0000; writes have no effect.
- Read path: every cycle, `DIN` is loaded with the decoded read value for the current `ADDR`. There is no read enable, and reads have no side effects.
- Read-during-write to the same location: `DIN` returns the old data (read-before-write) for all targets.
- Writes commit at the rising edge when `W`=1, using the `ADDR` and `DOUT` present in that cycle.
- SW passes through a two-flop synchronizer before decode.
- Timer:
  - A write to RELOAD also loads COUNT with the written value, truncated to TMR_W bits.
  - While EN=1 and COUNT≠0: COUNT decrements by 1 per cycle.
  - While EN=1 and COUNT=0: COUNT reloads from RELOAD and STATUS.expired is set.
  - With RELOAD=0 and EN=1: expired sets every cycle.
  - While EN=0: COUNT holds.
  - A RELOAD write in the same cycle as a decrement or reload wins; the written value is loaded.
  - Expiry in the same cycle as a write-1-clear: the set wins, and expired stays 1.
- `TmrFlag` = STATUS.expired.

## Timing
- Read latency is 1 cycle: `ADDR` valid in cycle k produces `DIN` valid in cycle k+1 and held until the next edge.
- Write latency is 1 edge: a read issued in the cycle after a write returns the new value.
- Back-to-back accesses are supported every cycle, and there are no stalls.
- SW latency: a switch change becomes visible on `DIN` 3 cycles after `ADDR` selects SW.
- Reset values:
  - `DIN`=0, `LEDR`=0, `TmrFlag`=0.
  - RELOAD=0, CTRL=0, COUNT=0.
  - Synchronizer flops = 0.
  - RAM contents are not reset and keep their values through reset.
- Reset mid-operation: a write with `W`=1 in a reset cycle commits to RAM, and is ignored by all reset-cleared registers. `DIN` is 0 in the cycle after reset regardless of `ADDR`.

## Structure
- Shared package holds:
  - region codes `REG_RAM`=4'h0, `REG_LED`=4'h1, `REG_SW`=4'h3, `REG_TMR`=4'h5;
  - timer offsets `TMR_RELOAD`=0, `TMR_CTRL`=1, `TMR_COUNT`=2, `TMR_STATUS`=3.
- Sub-module `ram_sync`: a single-port synchronous RAM with write enable and registered read-before-write output, sized by `RAM_AW`. The responder muxes its output with the registered peripheral read data, using the region code registered in the previous cycle.
- The timer sits in the top-level module, not in a separate sub-module.

## Test plan
- Reset, then drive `ADDR`=0x1000 with `W`=0 → `DIN`=0x0000 and `LEDR`=0.
- Write 0xBEEF to 0x0005, then read 0x0005 next cycle → `DIN`=0xBEEF one cycle after the read address. Then read 0x0105 → `DIN`=0xBEEF (aliasing).
- Same-cycle read/write: location 0x0007=0x1111; write 0x2222 with `ADDR`=0x0007 → `DIN`=0x1111 next cycle, then 0x2222 on the following read.
- Write 0x03FF to 0x1000 → `LEDR`=0x3FF. Write 0x1234 to 0x3000 → no effect. Read 0x7000 → 0x0000.
- Set `SW`=0x2A5 and hold `ADDR`=0x3000 → `DIN`=0x02A5 exactly 3 cycles after the SW change.
- Timer:
  - Write RELOAD=3, then CTRL=1 → COUNT reads 3, 2, 1, 0, and `TmrFlag` rises on the edge after COUNT=0, with COUNT=3 again.
  - Write STATUS=1 → `TmrFlag`=0.
  - Write STATUS=1 in the same cycle as an expiry → `TmrFlag` stays 1.
